tinymoa_alu_sequencer: RTL and testbench

TINYMOA_ALU_SEQUENCER -- requirements
Module: tinymoa_alu_sequencer

---
 rtl/tinymoa_pkg.sv | 30 +++
 rtl/tinymoa_nibble_mux.sv | 36 +++
 rtl/tinymoa_alu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_tinymoa_alu_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinymoa_pkg.sv
// Shared tinymoa definitions: sequencer state encodings, the ALU opcode
// width and the opcode values understood by the nibble ALU.
package tinymoa_pkg;

    // Width of one ALU slice; operands are processed this many bits at a time.
    localparam int NIBBLE_W = 4;

    // Opcode bus width driven to the nibble ALU.
    localparam int ALU_OP_W = 4;

    // Sequencer FSM encodings.
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // Opcodes implemented by the nibble ALU. The sequencer only forwards
    // them; it never interprets the opcode itself.
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_EQ  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'd4;

    // A new operation can be accepted whenever the sequencer is not mid-run.
    function automatic logic state_ready(input logic [STATE_W-1:0] st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/tinymoa_nibble_mux.sv
// Operand slicer: selects one 4-bit nibble out of a WIDTH-bit word.
// An index beyond the last nibble yields zero, so the output is always
// well defined even when NIBBLES is not a power of two.
module tinymoa_nibble_mux
    import tinymoa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0]    word,
    input  logic [IDX_W-1:0]    index,
    output logic [NIBBLE_W-1:0] nibble
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;

    logic [NIBBLE_W-1:0] slices [NIBBLES];

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
            assign slices[gi] = word[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    // Select the indexed slice; out-of-range indices fall through to zero.
    always_comb begin
        nibble = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (index == IDX_W'(i)) begin
                nibble = slices[i];
            end
        end
    end

endmodule

// File: rtl/tinymoa_alu_sequencer.sv
// Drives a 4-bit ALU one nibble per cycle, LSB nibble first, chaining the
// carry and compare bits between nibbles and assembling the WIDTH-bit
// result. A pulse on done marks result/carry/cmp valid.
module tinymoa_alu_sequencer
    import tinymoa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic                ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                carry_init,
    input  logic                cmp_init,
    output logic [ALU_OP_W-1:0] alu_opcode,
    output logic [NIBBLE_W-1:0] alu_a,
    output logic [NIBBLE_W-1:0] alu_b,
    output logic                alu_carry_in,
    output logic                alu_cmp_in,
    input  logic [NIBBLE_W-1:0] alu_result,
    input  logic                alu_carry_out,
    input  logic                alu_cmp_out,
    output logic [WIDTH-1:0]    result,
    output logic                carry,
    output logic                cmp,
    output logic                done
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIBBLE = CNT_W'(NIBBLES - 1);

    logic [STATE_W-1:0]  state_reg;
    logic [STATE_W-1:0]  state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ALU_OP_W-1:0] op_reg;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic                carry_reg;
    logic                cmp_reg;
    logic                done_reg;

    logic                accept;
    logic                in_run;
    logic                last_nibble;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;

    assign ready       = state_ready(state_reg);
    assign accept      = start & ready;
    assign in_run      = (state_reg == ST_RUN);
    assign last_nibble = in_run && (cnt_reg == LAST_NIBBLE);

    // Next-state logic: DONE can re-enter RUN directly for back-to-back ops.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == LAST_NIBBLE) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the request at accept; starts seen during RUN are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
        end else if (accept) begin
            op_reg <= op;
            a_reg  <= a;
            b_reg  <= b;
        end
    end

    // Nibble counter: cleared at accept, advances each RUN cycle and stops
    // on the last nibble so it never wraps within an operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
        end else if (in_run && !last_nibble) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Carry/compare chain: seeded from the init bits at accept, then
    // follows the ALU outputs nibble by nibble; after the last nibble it
    // holds the final values until the next accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            carry_reg <= 1'b0;
            cmp_reg   <= 1'b0;
        end else if (accept) begin
            carry_reg <= carry_init;
            cmp_reg   <= cmp_init;
        end else if (in_run) begin
            carry_reg <= alu_carry_out;
            cmp_reg   <= alu_cmp_out;
        end
    end

    // Completion pulse for the single DONE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= last_nibble;
        end
    end

    // One result register per nibble, written when the counter points at it.
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_result
            logic [NIBBLE_W-1:0] nib_reg;

            // Store this nibble's ALU result during its RUN cycle.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    nib_reg <= '0;
                end else if (in_run && (cnt_reg == CNT_W'(gi))) begin
                    nib_reg <= alu_result;
                end
            end

            assign result[gi*NIBBLE_W +: NIBBLE_W] = nib_reg;
        end
    endgenerate

    tinymoa_nibble_mux #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_mux_a (
        .word   (a_reg),
        .index  (cnt_reg),
        .nibble (nib_a)
    );

    tinymoa_nibble_mux #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_mux_b (
        .word   (b_reg),
        .index  (cnt_reg),
        .nibble (nib_b)
    );

    // ALU-facing operands and chain inputs are quiet outside RUN.
    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_carry_in = 1'b0;
        alu_cmp_in   = 1'b0;
        if (in_run) begin
            alu_a        = nib_a;
            alu_b        = nib_b;
            alu_carry_in = carry_reg;
            alu_cmp_in   = cmp_reg;
        end
    end

    assign alu_opcode = op_reg;
    assign carry      = carry_reg;
    assign cmp        = cmp_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_tinymoa_alu_sequencer.sv
// Bench for tinymoa_alu_sequencer: a nibble ALU model drives the DUT's ALU
// port, a word-level model predicts every observable output each cycle,
// and directed scenarios pin known results with literal values.
module tb_tinymoa_alu_sequencer;
    import tinymoa_pkg::*;

    localparam int W   = 32;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_init = 1'b0;
    logic         cmp_init = 1'b0;
    logic         ready;
    logic [3:0]   alu_opcode;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_carry_in;
    logic         alu_cmp_in;
    logic [3:0]   alu_result;
    logic         alu_carry_out;
    logic         alu_cmp_out;
    logic [W-1:0] result;
    logic         carry;
    logic         cmp;
    logic         done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tinymoa_alu_sequencer #(.WIDTH(W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .ready         (ready),
        .op            (op),
        .a             (a),
        .b             (b),
        .carry_init    (carry_init),
        .cmp_init      (cmp_init),
        .alu_opcode    (alu_opcode),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry_in  (alu_carry_in),
        .alu_cmp_in    (alu_cmp_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .alu_cmp_out   (alu_cmp_out),
        .result        (result),
        .carry         (carry),
        .cmp           (cmp),
        .done          (done)
    );

    // Combinational 4-bit ALU attached to the sequencer.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum       = '0;
        alu_result    = '0;
        alu_carry_out = alu_carry_in;
        alu_cmp_out   = alu_cmp_in;
        case (alu_opcode)
            ALU_OP_ADD: begin
                alu_sum       = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_carry_in};
                alu_result    = alu_sum[3:0];
                alu_carry_out = alu_sum[4];
            end
            ALU_OP_SUB: begin
                alu_sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_carry_in};
                alu_result    = alu_sum[3:0];
                alu_carry_out = alu_sum[4];
            end
            ALU_OP_EQ: begin
                alu_result  = alu_a ^ alu_b;
                alu_cmp_out = alu_cmp_in & (alu_a == alu_b);
            end
            ALU_OP_XOR: alu_result = alu_a ^ alu_b;
            ALU_OP_AND: alu_result = alu_a & alu_b;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry and compare that must enter nibble k: the chain produced by the
    // low 4k bits of the whole-word operation (k = NIB gives the final values).
    function automatic logic [1:0] chain_at(input logic [3:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic ci,
                                            input logic mi, input int k);
        logic [W:0] one;
        logic [W:0] mask;
        logic [W:0] xs;
        logic [W:0] ys;
        logic [W:0] s;
        one  = 1;
        mask = (one << (4 * k)) - one;
        xs   = {1'b0, x} & mask;
        ys   = {1'b0, y} & mask;
        case (o)
            ALU_OP_ADD: begin
                s = xs + ys + {{W{1'b0}}, ci};
                return {s[4*k], mi};
            end
            ALU_OP_SUB: begin
                s = xs + ({1'b0, ~y} & mask) + {{W{1'b0}}, ci};
                return {s[4*k], mi};
            end
            ALU_OP_EQ: return {ci, mi & (xs == ys)};
            default:   return {ci, mi};
        endcase
    endfunction

    function automatic logic [W-1:0] word_result(input logic [3:0] o, input logic [W-1:0] x,
                                                 input logic [W-1:0] y, input logic ci);
        case (o)
            ALU_OP_ADD: return x + y + {{(W-1){1'b0}}, ci};
            ALU_OP_SUB: return x + ~y + {{(W-1){1'b0}}, ci};
            ALU_OP_EQ:  return x ^ y;
            ALU_OP_XOR: return x ^ y;
            ALU_OP_AND: return x & y;
            default:    return '0;
        endcase
    endfunction

    // Reference model: m_k is the nibble in progress, -1 when not running.
    int           m_k = -1;
    logic         m_done = 1'b0;
    logic [3:0]   m_op = '0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         m_ci = 1'b0;
    logic         m_mi = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_carry = 1'b0;
    logic         m_cmp = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_k = -1; m_done = 1'b0; m_op = '0; m_a = '0; m_b = '0;
            m_ci = 1'b0; m_mi = 1'b0; m_res = '0; m_carry = 1'b0; m_cmp = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_k < 0) begin
                if (start) begin
                    m_op = op; m_a = a; m_b = b; m_ci = carry_init; m_mi = cmp_init;
                    m_k = 0;
                end
            end else if (m_k == NIB - 1) begin
                m_k    = -1;
                m_done = 1'b1;
                m_res  = word_result(m_op, m_a, m_b, m_ci);
                {m_carry, m_cmp} = chain_at(m_op, m_a, m_b, m_ci, m_mi, NIB);
            end else begin
                m_k++;
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the clock edge.
    logic [1:0] exp_chain;
    always @(negedge clk) begin
        if (rstn) begin
            check("ready", 64'(ready), 64'(m_k < 0));
            check("done", 64'(done), 64'(m_done));
            check("alu_opcode", 64'(alu_opcode), 64'(m_op));
            if (m_k >= 0) begin
                exp_chain = chain_at(m_op, m_a, m_b, m_ci, m_mi, m_k);
                check("alu_a", 64'(alu_a), 64'(m_a[4*m_k +: 4]));
                check("alu_b", 64'(alu_b), 64'(m_b[4*m_k +: 4]));
                check("alu_carry_in", 64'(alu_carry_in), 64'(exp_chain[1]));
                check("alu_cmp_in", 64'(alu_cmp_in), 64'(exp_chain[0]));
            end else begin
                check("alu_a_idle", 64'(alu_a), 64'd0);
                check("alu_b_idle", 64'(alu_b), 64'd0);
                check("alu_cin_idle", 64'(alu_carry_in), 64'd0);
                check("alu_cmpin_idle", 64'(alu_cmp_in), 64'd0);
                check("result", 64'(result), 64'(m_res));
                check("carry", 64'(carry), 64'(m_carry));
                check("cmp", 64'(cmp), 64'(m_cmp));
            end
        end
    end

    // Stimulus helpers.
    logic [3:0]   obs_a [NIB];
    int           inject_at = 0;

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic mi);
        op = o; a = x; b = y; carry_init = ci; cmp_init = mi; start = 1'b1;
    endtask

    // Waits for done; lat = cycles from the accepting edge (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (inject_at != 0 && c == inject_at) begin
                op = ALU_OP_XOR; a = 32'hA5A5_A5A5; b = 32'h0F0F_0F0F;
                carry_init = 1'b1; start = 1'b1;
            end
            if (inject_at != 0 && c == inject_at + 1) start = 1'b0;
            @(negedge clk);
            if (c <= NIB) obs_a[c-1] = alu_a;
            if (done) begin
                lat = c;
                return;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int lat;
        int cnt;
        logic [3:0] rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic b2b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_opcode", 64'(alu_opcode), 64'd0);

        // All-ones plus one: full carry ripple.
        @(posedge clk); #1;
        issue(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_done(lat);
        check("add_ovf_latency", 64'(lat), 64'd9);
        check("add_ovf_result", 64'(result), 64'h0000_0000);
        check("add_ovf_carry", 64'(carry), 64'd1);

        // Operand nibbles presented LSB first.
        @(posedge clk); #1;
        issue(ALU_OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done(lat);
        check("add_seq_result", 64'(result), 64'h2345_6789);
        check("add_seq_carry", 64'(carry), 64'd0);
        for (int i = 0; i < NIB; i++) check("alu_a_seq", 64'(obs_a[i]), 64'(8 - i));

        // Equality compare.
        @(posedge clk); #1;
        issue(ALU_OP_EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_done(lat);
        check("eq_same_cmp", 64'(cmp), 64'd1);
        @(posedge clk); #1;
        issue(ALU_OP_EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0, 1'b1);
        wait_done(lat);
        check("eq_diff_cmp", 64'(cmp), 64'd0);

        // Start during RUN must be ignored.
        @(posedge clk); #1;
        inject_at = 3;
        issue(ALU_OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        wait_done(lat);
        inject_at = 0;
        check("run_start_latency", 64'(lat), 64'd9);
        check("run_start_result", 64'(result), 64'h0000_0003);
        count_done(12, cnt);
        check("run_start_no_extra_done", 64'(cnt), 64'd0);

        // Back-to-back: second start issued in the DONE cycle.
        @(posedge clk); #1;
        issue(ALU_OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0);
        wait_done(lat);
        check("b2b_first_result", 64'(result), 64'hF0F0_0F0F);
        check("b2b_ready_in_done", 64'(ready), 64'd1);
        issue(ALU_OP_ADD, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
        wait_done(lat);
        check("b2b_second_latency", 64'(lat), 64'd9);
        check("b2b_second_result", 64'(result), 64'h0000_000C);

        // Reset asserted while nibble 4 is in progress.
        @(posedge clk); #1;
        issue(ALU_OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_carry", 64'(carry), 64'd0);
        check("mid_rst_cmp", 64'(cmp), 64'd0);
        check("mid_rst_opcode", 64'(alu_opcode), 64'd0);
        check("mid_rst_alu_a", 64'(alu_a), 64'd0);
        count_done(3, cnt);
        @(negedge clk);
        #2 rstn = 1'b1;
        count_done(12, lat);
        check("mid_rst_no_done", 64'(cnt + lat), 64'd0);
        @(posedge clk); #1;
        issue(ALU_OP_SUB, 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0);
        wait_done(lat);
        check("post_rst_latency", 64'(lat), 64'd9);
        check("post_rst_result", 64'(result), 64'h0000_000F);
        check("post_rst_carry", 64'(carry), 64'd1);

        // Randomized operations, occasionally back-to-back.
        b2b = 1'b0;
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 4));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if (!b2b) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                @(posedge clk); #1;
            end
            issue(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(lat);
            check("rand_latency", 64'(lat), 64'd9);
            b2b = ($urandom_range(0, 2) == 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
